loop_addr_gen: RTL
==================

# loop_addr_gen

Address sequencer for the looper memory path. It generates the 27-bit word address for the Ram2Ddr interface as `block*8 + bank`, so each sample slot visits banks 0–7 in turn before the block counter advances. It also owns the loop length (`max_block`). It sits between `mem_ctrl`, which pulses `step` once per completed RAM access, and the `ram_a` input of Ram2Ddr.

## Interface
Parameters:
- `BLOCK_W`, 23: block counter width.
- `MAX_BLOCK_LIMIT`, 8000000: block count used when no loop length is latched (64 M words / 8 banks).
- `TENHZ`, 10000000: `clk_100MHz` cycles per 0.1 s; used only with `LOOP_ADDR_TIMER_EN`.

Ports:
- `clk_100MHz`, in, 1: sole clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `step`, in, 1: one-cycle pulse; advance to the next bank/block.
- `set_max`, in, 1: one-cycle pulse; latch the loop length at the end of the first recording.
- `reset_max`, in, 1: one-cycle pulse; clear the loop length.
- `ram_a`, out, 27: `{1'b0, current_block, current_bank}`.
- `current_bank`, out, 3: bank index 0–7.
- `current_block`, out, 23: block index.
- `max_block`, out, 23: latched loop length in blocks; 0 when none is latched.
- `max_valid`, out, 1: a loop length is latched.
- `block_tick`, out, 1: one-cycle pulse when the block changes.
- `loop_wrap`, out, 1: one-cycle pulse when the block returns to 0.
- `timerval`, out, 12: tenths of seconds since the last wrap.

## Operation
- Reset (async, `rst`=1): every output and internal register is 0, including `ram_a`, `max_valid`, `timerval` and the prescaler.
- Limit L = `max_block` if `max_valid`, else `MAX_BLOCK_LIMIT`.
- On `step` with `set_max`=0:
  - If bank < 7: bank increments.
  - If bank = 7: bank goes to 0, `block_tick` pulses, and the block updates as follows.
    - If block+1 = L: block goes to 0 and `loop_wrap` pulses.
    - Otherwise: block increments.
- `set_max` with `max_valid`=0:
  - `max_block` <= `current_block`+1, where `current_block` is its value before this cycle.
  - `max_valid` <= 1.
  - Block and bank go to 0.
  - `loop_wrap` pulses; `block_tick` does not.
  - A `step` in the same cycle is discarded.
- `set_max` with `max_valid`=1: ignored. The length stays locked until `reset_max`.
- `reset_max`:
  - `max_valid` <= 0 and `max_block` <= 0.
  - Block and bank are untouched.
  - A `step` in the same cycle is processed normally against `MAX_BLOCK_LIMIT`.
  - Wins over a simultaneous `set_max`, which is then ignored.
- If `max_valid` becomes 0 while block ≥ `MAX_BLOCK_LIMIT`: unreachable, because `max_block` ≤ `MAX_BLOCK_LIMIT` by construction. The bench checks this holds.
- Arithmetic: block+1 is computed at `BLOCK_W`+1 bits, so there is no overflow aliasing at `2^BLOCK_W`-1.

## Timing
- All outputs are registered.
- `ram_a`, `current_bank`, `current_block`, `max_block` and `max_valid` take their new values on the clock edge that samples the input pulse. They are visible from the next cycle.
- `block_tick` and `loop_wrap` are high for exactly the cycle in which the new block value first appears.
- Back-to-back `step` pulses, one per cycle, are supported at full rate with no stall.
- Deasserting `rst` mid-sequence restarts at address 0. There is no handshake, because `mem_ctrl` issues `step` only after its access completes.

## Configuration
- `LOOP_ADDR_TIMER_EN` defined:
  - A prescaler counts `TENHZ` cycles.
  - `timerval` increments once per prescaler period and saturates at 4095.
  - `timerval` and the prescaler both clear to 0 in the cycle `loop_wrap` is asserted.
- `LOOP_ADDR_TIMER_EN` not defined:
  - `timerval` is tied to 12'd0.
  - No prescaler logic is instantiated.

## Test plan
- Reset, then 8 `step` pulses: `ram_a` runs 0..7, then reads 8 (block 1, bank 0), and `block_tick` pulses once.
- 8·5 `step` pulses (block=5), then `set_max`: `max_block`=6, `max_valid`=1, `ram_a`=0, `loop_wrap`=1 for one cycle.
- With `max_block`=6: 48 `step` pulses give `loop_wrap` on the 48th, `ram_a` returns to 0, and block never reads 6.
- `set_max` together with `reset_max` while `max_valid`=1: `max_valid`=0, `max_block`=0, and block/bank are unchanged. A second `set_max` afterwards latches the new value.
- With `MAX_BLOCK_LIMIT`=4 overridden: 32 `step` pulses wrap to 0 with `loop_wrap`. Assert `rst` mid-run with bank=3: all outputs read 0 asynchronously.
- With `LOOP_ADDR_TIMER_EN` and `TENHZ`=10: after 35 idle cycles `timerval`=3; `loop_wrap` clears it to 0; forced long idle saturates it at 4095.

Source files
------------

// File: rtl/loop_addr_gen.sv
// loop_addr_gen -- word address sequencer for the looper memory path.
//
// Produces ram_a = {1'b0, current_block, current_bank}. Every step pulse from
// mem_ctrl advances the bank (0..7). After bank 7 the block advances, and it
// wraps at the loop limit. The loop limit is the latched max_block when
// max_valid is set, and MAX_BLOCK_LIMIT otherwise.
//
// Optional feature (macro LOOP_ADDR_TIMER_EN): a prescaler of TENHZ cycles
// drives timerval, which counts tenths of a second since the last loop_wrap
// and saturates at 4095. Without the macro, timerval is tied to zero.
//
// Ports:
//   clk_100MHz    in   sole clock, rising edge
//   rst           in   asynchronous, active-high reset
//   step          in   one-cycle pulse: advance bank/block
//   set_max       in   one-cycle pulse: latch loop length (first recording)
//   reset_max     in   one-cycle pulse: clear loop length (wins over set_max)
//   ram_a         out  27-bit word address
//   current_bank  out  bank index 0..7
//   current_block out  block index
//   max_block     out  latched loop length in blocks, 0 if none
//   max_valid     out  loop length latched
//   block_tick    out  pulse in the first cycle a new block value is visible
//   loop_wrap     out  pulse in the first cycle the block reads 0 after a wrap
//   timerval      out  tenths of seconds since the last wrap
//
// Control signals are plain one-cycle pulses sampled on the rising edge. There
// is no valid/ready handshake because mem_ctrl only pulses step after its
// access has completed, so every pulse is consumed in the cycle it arrives.
module loop_addr_gen #(
  parameter int BLOCK_W         = 23,
  parameter int MAX_BLOCK_LIMIT = 8000000,
  parameter int TENHZ           = 10000000
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  input  logic               step,
  input  logic               set_max,
  input  logic               reset_max,
  output logic [26:0]        ram_a,
  output logic [2:0]         current_bank,
  output logic [BLOCK_W-1:0] current_block,
  output logic [BLOCK_W-1:0] max_block,
  output logic               max_valid,
  output logic               block_tick,
  output logic               loop_wrap,
  output logic [11:0]        timerval
);

  localparam logic [BLOCK_W:0] DEF_LIMIT = (BLOCK_W+1)'(MAX_BLOCK_LIMIT);

  // The increment is one bit wider than the block counter, so that the
  // comparison against the limit cannot alias at 2^BLOCK_W-1.
  logic [BLOCK_W:0]   block_inc;
  logic [BLOCK_W:0]   limit;
  logic [2:0]         bank_nx;
  logic [BLOCK_W-1:0] block_nx;
  logic [BLOCK_W-1:0] max_nx;
  logic               valid_nx;
  logic               tick_nx;
  logic               wrap_nx;

  assign block_inc = {1'b0, current_block} + (BLOCK_W+1)'(1);

  always_comb begin
    bank_nx  = current_bank;
    block_nx = current_block;
    max_nx   = max_block;
    valid_nx = max_valid;
    tick_nx  = 1'b0;
    wrap_nx  = 1'b0;
    // A reset_max in this cycle makes a simultaneous step use the default limit.
    limit    = (max_valid && !reset_max) ? {1'b0, max_block} : DEF_LIMIT;

    if (reset_max) begin
      valid_nx = 1'b0;
      max_nx   = '0;
    end

    if (set_max && !max_valid && !reset_max) begin
      // The end of the first recording closes the loop. The current block
      // counts as recorded, and any step in this cycle is dropped.
      max_nx   = block_inc[BLOCK_W-1:0];
      valid_nx = 1'b1;
      bank_nx  = 3'd0;
      block_nx = '0;
      wrap_nx  = 1'b1;
    end else if (step) begin
      if (current_bank != 3'd7) begin
        bank_nx = current_bank + 3'd1;
      end else begin
        bank_nx = 3'd0;
        tick_nx = 1'b1;
        if (block_inc == limit) begin
          block_nx = '0;
          wrap_nx  = 1'b1;
        end else begin
          block_nx = block_inc[BLOCK_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      current_bank  <= 3'd0;
      current_block <= '0;
      max_block     <= '0;
      max_valid     <= 1'b0;
      block_tick    <= 1'b0;
      loop_wrap     <= 1'b0;
      ram_a         <= 27'd0;
    end else begin
      current_bank  <= bank_nx;
      current_block <= block_nx;
      max_block     <= max_nx;
      max_valid     <= valid_nx;
      block_tick    <= tick_nx;
      loop_wrap     <= wrap_nx;
      ram_a         <= 27'({block_nx, bank_nx});
    end
  end

`ifdef LOOP_ADDR_TIMER_EN
  localparam int PRE_W = (TENHZ > 1) ? $clog2(TENHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TENHZ - 1);

  logic [PRE_W-1:0] prescale;

  // The timer and the prescaler clear on the same edge that raises loop_wrap,
  // so timerval reads 0 in the cycle loop_wrap is high.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      timerval <= 12'd0;
    end else if (wrap_nx) begin
      prescale <= '0;
      timerval <= 12'd0;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
      if (timerval != 12'hFFF) timerval <= timerval + 12'd1;
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end
`else
  assign timerval = 12'd0;

  // TENHZ only sizes the prescaler. This empty block marks an invalid
  // override in the elaborated hierarchy even when the timer is absent.
  if (TENHZ < 1) begin : g_tenhz_invalid
  end
`endif

endmodule
